mac_table_scheduler: RTL and testbench
======================================

# mac_table_scheduler

Front-end controller for the MAC address table. Shares the table's single lookup port among `NUM_PORTS` ingress requesters using round-robin arbitration and routes each result back to its requester. Issues periodic garbage-collection sweeps. Serialises management read and delete requests so that they never overlap a sweep. Sits between the ingress port logic and the MAC address table, and drives every table input.

## Interface
- `NUM_PORTS`, 4: number of lookup requesters (1..32); requester index is used as the source port.
- `LOOKUP_LATENCY`, 4: cycles from `tbl_lookup_en` to valid `tbl_lookup_hit`/`tbl_lookup_dst_port`.
- `GC_INTERVAL`, 156250000: cycles between automatic GC sweeps (1 s at 156.25 MHz); 32 bits.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_en` in NUM_PORTS: per-requester lookup request; held until acked.
- `req_vlan` in 12*NUM_PORTS: source VLAN, slice i belongs to requester i.
- `req_src_mac`, `req_dst_mac` in 48*NUM_PORTS each: source and destination MAC addresses.
- `req_ack` out NUM_PORTS: one-hot, combinational; request is accepted this cycle.
- `rsp_valid` out NUM_PORTS: one-hot result strobe.
- `rsp_hit` out 1, `rsp_dst_port` out 5: result, qualified by `rsp_valid`.
- `gc_force` in 1: request an immediate sweep.
- `gc_busy` out 1: a sweep is in progress.
- `mgmt_rd_en`, `mgmt_del_en` in 1 each: management read or delete request.
- `mgmt_addr` in 11, `mgmt_way` in 3: target table row and way.
- `mgmt_busy` out 1: a management request is pending or outstanding.
- `mgmt_ack` out 1: the management operation completed.
- `tbl_lookup_en`, `tbl_lookup_src_vlan`, `tbl_lookup_src_mac`, `tbl_lookup_src_port`, `tbl_lookup_dst_mac` out: registered drive to the table lookup port.
- `tbl_lookup_hit`, `tbl_lookup_dst_port` in: lookup result from the table.
- `tbl_gc_en` out, `tbl_gc_done` in: garbage-collection handshake with the table.
- `tbl_mgmt_rd_en`, `tbl_mgmt_del_en`, `tbl_mgmt_addr`, `tbl_mgmt_way` out: management drive to the table.
- `tbl_mgmt_ack` in: management completion from the table.

## Operation
- **Arbitration**
  - Round-robin pointer `rr` (reset 0). Grant goes to the first i ≥ `rr` (wrapping) with `req_en[i]`.
  - On a grant, `rr` ← i+1, wrapping to 0 at `NUM_PORTS`.
  - At most one grant per cycle. Ungranted requesters hold their request.
- **Tag pipeline**
  - Shift register of `LOOKUP_LATENCY` entries, each {valid, port index}, advanced every cycle.
  - The tag at the output aligns with the table result. That result is registered onto `rsp_*`, and `rsp_valid[port]` is pulsed.
- **GC state machine**
  - States: IDLE, ISSUE, WAIT.
  - 32-bit down-counter, reset to `GC_INTERVAL`-1. It decrements in IDLE only.
  - IDLE → ISSUE when the counter reaches 0 or `gc_force`=1, unless a management operation is outstanding. In that case the start is deferred and the counter holds at 0.
  - ISSUE: `tbl_gc_en`=1 for exactly one cycle, then → WAIT.
  - WAIT: on `tbl_gc_done` → IDLE and reload the counter.
  - `gc_force` outside IDLE is ignored.
  - `gc_busy` = (state ≠ IDLE).
  - Lookups continue during a sweep.
- **Management**
  - Single-entry pending latch. A request is captured when `mgmt_busy`=0.
  - If read and delete are both asserted, delete wins.
  - A pending request is forwarded as a one-cycle `tbl_mgmt_*` pulse only while the GC state is IDLE and no GC start is scheduled that cycle.
  - Then the block waits for `tbl_mgmt_ack` and pulses `mgmt_ack` one cycle later.
  - `mgmt_busy` is set from capture through the `mgmt_ack` cycle inclusive.
- **Reset**: all outputs, the pointer, tags and FSM states are 0 or IDLE; the GC counter is `GC_INTERVAL`-1. Reset asserted mid-sweep or mid-management operation discards all state, and no ack is produced.

## Timing
- `req_ack` is at cycle T, `tbl_lookup_*` is valid at T+1, and `rsp_valid` is at T+2+`LOOKUP_LATENCY`.
- Full throughput: one lookup per cycle sustained, with results in grant order.
- The first automatic GC issue is `GC_INTERVAL` cycles after reset deassertion.
- Management latency when idle: capture at cycle C, `tbl_mgmt_*` at C+1, `mgmt_ack` one cycle after `tbl_mgmt_ack`.
- If `gc_force` and a pending management request occur in the same IDLE cycle, GC wins and management waits for `tbl_gc_done`.

## Test plan
- **Single lookup**: requester 2 requests VLAN 2, src 02deadbeef0c, dst 02deadbeef0a → `req_ack`=0b0100 the same cycle; `tbl_lookup_src_port`=2 at T+1; `rsp_valid`=0b0100 at T+6.
- **Fairness**: all 4 requesters held high for 8 cycles → grants 0,1,2,3,0,1,2,3; each `rsp_valid` routes to the matching index.
- **Automatic GC** (`GC_INTERVAL`=16): `tbl_gc_en` pulses at cycle 16 after reset; `gc_busy` stays high until the cycle after `tbl_gc_done`; the next pulse comes 16 cycles after that.
- **Deferred management**: with `gc_force` and `mgmt_rd_en` (addr 068, way 0) asserted together → GC is issued first, `tbl_mgmt_rd_en` only after `tbl_gc_done`, then `mgmt_ack`.
- **Deferred GC**: management delete (addr 06e) outstanding when the GC counter expires → `tbl_gc_en` is held off until the cycle after `mgmt_ack`.
- **Reset mid-sweep**: `rst_n` low during WAIT → `gc_busy`=0, `rsp_valid`=0 and the counter reloads; no spurious `mgmt_ack` after release.

Source files
------------

// File: rtl/mac_table_scheduler.sv
// Front-end for the MAC address table: round-robin lookup arbitration with
// result routing, periodic garbage-collection sweeps, and serialised management access.
module mac_table_scheduler #(
    parameter int          NUM_PORTS      = 4,
    parameter int          LOOKUP_LATENCY = 4,
    parameter logic [31:0] GC_INTERVAL    = 32'd156250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    req_en,
    input  logic [12*NUM_PORTS-1:0] req_vlan,
    input  logic [48*NUM_PORTS-1:0] req_src_mac,
    input  logic [48*NUM_PORTS-1:0] req_dst_mac,
    output logic [NUM_PORTS-1:0]    req_ack,
    output logic [NUM_PORTS-1:0]    rsp_valid,
    output logic                    rsp_hit,
    output logic [4:0]              rsp_dst_port,
    input  logic                    gc_force,
    output logic                    gc_busy,
    input  logic                    mgmt_rd_en,
    input  logic                    mgmt_del_en,
    input  logic [10:0]             mgmt_addr,
    input  logic [2:0]              mgmt_way,
    output logic                    mgmt_busy,
    output logic                    mgmt_ack,
    output logic                    tbl_lookup_en,
    output logic [11:0]             tbl_lookup_src_vlan,
    output logic [47:0]             tbl_lookup_src_mac,
    output logic [4:0]              tbl_lookup_src_port,
    output logic [47:0]             tbl_lookup_dst_mac,
    input  logic                    tbl_lookup_hit,
    input  logic [4:0]              tbl_lookup_dst_port,
    output logic                    tbl_gc_en,
    input  logic                    tbl_gc_done,
    output logic                    tbl_mgmt_rd_en,
    output logic                    tbl_mgmt_del_en,
    output logic [10:0]             tbl_mgmt_addr,
    output logic [2:0]              tbl_mgmt_way,
    input  logic                    tbl_mgmt_ack
);

    typedef enum logic [1:0] {GC_IDLE, GC_ISSUE, GC_WAIT} gc_state_t;
    typedef enum logic [1:0] {MG_IDLE, MG_PEND, MG_WAIT, MG_ACK} mg_state_t;

    logic [4:0]  rr_r;
    logic [31:0] req_ext_s;
    logic [5:0]  cand_s;
    logic        pick_s;
    logic        grant_found_s;
    logic [4:0]  grant_idx_s;
    logic [11:0] sel_vlan_s;
    logic [47:0] sel_src_s;
    logic [47:0] sel_dst_s;

    logic [LOOKUP_LATENCY-1:0] tag_v_r;
    logic [4:0]                tag_p_r [LOOKUP_LATENCY];

    gc_state_t   gc_state_r;
    logic [31:0] gc_cnt_r;
    logic        gc_start_s;

    mg_state_t   mg_state_r;
    logic        pend_del_r;
    logic [10:0] pend_addr_r;
    logic [2:0]  pend_way_r;
    logic        cap_s;
    logic        fwd_s;
    logic        req_del_s;
    logic [10:0] req_addr_s;
    logic [2:0]  req_way_s;

    assign req_ext_s = 32'(req_en);

    // Round-robin search starting at rr_r, wrapping at NUM_PORTS
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = 5'd0;
        cand_s        = 6'd0;
        pick_s        = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s        = 6'(rr_r) + 6'(k);
            cand_s        = (cand_s >= 6'(NUM_PORTS)) ? cand_s - 6'(NUM_PORTS) : cand_s;
            pick_s        = req_ext_s[cand_s[4:0]] & ~grant_found_s;
            grant_idx_s   = pick_s ? cand_s[4:0] : grant_idx_s;
            grant_found_s = grant_found_s | pick_s;
        end
    end

    assign req_ack = grant_found_s ? NUM_PORTS'(32'd1 << grant_idx_s) : '0;

    // One-hot mux of the granted requester's lookup key
    always_comb begin
        sel_vlan_s = 12'd0;
        sel_src_s  = 48'd0;
        sel_dst_s  = 48'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_vlan_s = sel_vlan_s | (req_vlan[i*12 +: 12] & {12{req_ack[i]}});
            sel_src_s  = sel_src_s  | (req_src_mac[i*48 +: 48] & {48{req_ack[i]}});
            sel_dst_s  = sel_dst_s  | (req_dst_mac[i*48 +: 48] & {48{req_ack[i]}});
        end
    end

    // Lookup issue, tag pipeline aligned with table latency, and result routing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r                <= 5'd0;
            tbl_lookup_en       <= 1'b0;
            tbl_lookup_src_vlan <= 12'd0;
            tbl_lookup_src_mac  <= 48'd0;
            tbl_lookup_src_port <= 5'd0;
            tbl_lookup_dst_mac  <= 48'd0;
            tag_v_r             <= '0;
            for (int i = 0; i < LOOKUP_LATENCY; i++) tag_p_r[i] <= 5'd0;
            rsp_valid           <= '0;
            rsp_hit             <= 1'b0;
            rsp_dst_port        <= 5'd0;
        end else begin
            if (grant_found_s)
                rr_r <= (grant_idx_s == 5'(NUM_PORTS-1)) ? 5'd0 : grant_idx_s + 5'd1;
            else
                rr_r <= rr_r;
            tbl_lookup_en       <= grant_found_s;
            tbl_lookup_src_vlan <= sel_vlan_s;
            tbl_lookup_src_mac  <= sel_src_s;
            tbl_lookup_src_port <= grant_idx_s;
            tbl_lookup_dst_mac  <= sel_dst_s;
            tag_v_r[0]          <= tbl_lookup_en;
            tag_p_r[0]          <= tbl_lookup_src_port;
            for (int i = 1; i < LOOKUP_LATENCY; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_p_r[i] <= tag_p_r[i-1];
            end
            if (tag_v_r[LOOKUP_LATENCY-1]) begin
                rsp_valid    <= NUM_PORTS'(32'd1 << tag_p_r[LOOKUP_LATENCY-1]);
                rsp_hit      <= tbl_lookup_hit;
                rsp_dst_port <= tbl_lookup_dst_port;
            end else begin
                rsp_valid    <= '0;
                rsp_hit      <= rsp_hit;
                rsp_dst_port <= rsp_dst_port;
            end
        end
    end

    // A sweep may start only while no forwarded management op awaits the table
    assign gc_start_s = (gc_state_r == GC_IDLE) && ((gc_cnt_r == 32'd0) || gc_force)
                        && (mg_state_r != MG_WAIT);
    assign gc_busy    = (gc_state_r != GC_IDLE);

    // GC sweep FSM with interval down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gc_state_r <= GC_IDLE;
            gc_cnt_r   <= GC_INTERVAL - 32'd1;
            tbl_gc_en  <= 1'b0;
        end else begin
            case (gc_state_r)
                GC_IDLE: begin
                    if (gc_start_s) begin
                        gc_state_r <= GC_ISSUE;
                        tbl_gc_en  <= 1'b1;
                    end else begin
                        gc_cnt_r   <= (gc_cnt_r == 32'd0) ? 32'd0 : gc_cnt_r - 32'd1;
                        tbl_gc_en  <= 1'b0;
                    end
                end
                GC_ISSUE: begin
                    gc_state_r <= GC_WAIT;
                    tbl_gc_en  <= 1'b0;
                end
                GC_WAIT: begin
                    tbl_gc_en <= 1'b0;
                    if (tbl_gc_done) begin
                        gc_state_r <= GC_IDLE;
                        gc_cnt_r   <= GC_INTERVAL - 32'd1;
                    end else begin
                        gc_state_r <= GC_WAIT;
                    end
                end
                default: begin
                    gc_state_r <= GC_IDLE;
                    tbl_gc_en  <= 1'b0;
                end
            endcase
        end
    end

    assign cap_s      = (mg_state_r == MG_IDLE) && (mgmt_rd_en || mgmt_del_en);
    assign fwd_s      = (cap_s || (mg_state_r == MG_PEND)) && (gc_state_r == GC_IDLE) && !gc_start_s;
    assign req_del_s  = cap_s ? mgmt_del_en : pend_del_r;
    assign req_addr_s = cap_s ? mgmt_addr   : pend_addr_r;
    assign req_way_s  = cap_s ? mgmt_way    : pend_way_r;
    assign mgmt_busy  = (mg_state_r != MG_IDLE);

    // Management request latch, forwarding and completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mg_state_r      <= MG_IDLE;
            pend_del_r      <= 1'b0;
            pend_addr_r     <= 11'd0;
            pend_way_r      <= 3'd0;
            tbl_mgmt_rd_en  <= 1'b0;
            tbl_mgmt_del_en <= 1'b0;
            tbl_mgmt_addr   <= 11'd0;
            tbl_mgmt_way    <= 3'd0;
            mgmt_ack        <= 1'b0;
        end else begin
            tbl_mgmt_rd_en  <= fwd_s & ~req_del_s;
            tbl_mgmt_del_en <= fwd_s & req_del_s;
            tbl_mgmt_addr   <= fwd_s ? req_addr_s : tbl_mgmt_addr;
            tbl_mgmt_way    <= fwd_s ? req_way_s  : tbl_mgmt_way;
            mgmt_ack        <= (mg_state_r == MG_WAIT) && tbl_mgmt_ack;
            pend_del_r      <= req_del_s;
            pend_addr_r     <= req_addr_s;
            pend_way_r      <= req_way_s;
            case (mg_state_r)
                MG_IDLE: mg_state_r <= cap_s ? (fwd_s ? MG_WAIT : MG_PEND) : MG_IDLE;
                MG_PEND: mg_state_r <= fwd_s ? MG_WAIT : MG_PEND;
                MG_WAIT: mg_state_r <= tbl_mgmt_ack ? MG_ACK : MG_WAIT;
                MG_ACK:  mg_state_r <= MG_IDLE;
                default: mg_state_r <= MG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_table_scheduler.sv
// Directed bench for mac_table_scheduler: table-driven arbitration vectors plus
// hand sequences for GC timing, management/GC interlock and reset mid-sweep.
module tb_mac_table_scheduler;

    localparam int NP  = 4;
    localparam int LAT = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP-1:0]  req_en = '0;
    logic [12*NP-1:0] req_vlan;
    logic [48*NP-1:0] req_src_mac, req_dst_mac;
    logic [NP-1:0]  req_ack, rsp_valid;
    logic           rsp_hit;
    logic [4:0]     rsp_dst_port;
    logic           gc_force = 1'b0, gc_busy;
    logic           mgmt_rd_en = 1'b0, mgmt_del_en = 1'b0;
    logic [10:0]    mgmt_addr = 11'd0;
    logic [2:0]     mgmt_way = 3'd0;
    logic           mgmt_busy, mgmt_ack;
    logic           tbl_lookup_en;
    logic [11:0]    tbl_lookup_src_vlan;
    logic [47:0]    tbl_lookup_src_mac, tbl_lookup_dst_mac;
    logic [4:0]     tbl_lookup_src_port;
    logic           tbl_lookup_hit;
    logic [4:0]     tbl_lookup_dst_port;
    logic           tbl_gc_en, tbl_gc_done;
    logic           tbl_mgmt_rd_en, tbl_mgmt_del_en, tbl_mgmt_ack;
    logic [10:0]    tbl_mgmt_addr;
    logic [2:0]     tbl_mgmt_way;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gc_delay = 2;
    int mg_delay = 1;
    int gc_cd = 0;
    int mg_cd = 0;

    logic [47:0] src_tab [NP];
    logic [47:0] dst_tab [NP];

    typedef struct {
        int         cyc;
        logic [3:0] vld;
        logic       hit;
        logic [4:0] dst;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ack;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_table_scheduler #(
        .NUM_PORTS(NP), .LOOKUP_LATENCY(LAT), .GC_INTERVAL(32'd16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_en(req_en), .req_vlan(req_vlan), .req_src_mac(req_src_mac), .req_dst_mac(req_dst_mac),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_dst_port(rsp_dst_port),
        .gc_force(gc_force), .gc_busy(gc_busy),
        .mgmt_rd_en(mgmt_rd_en), .mgmt_del_en(mgmt_del_en), .mgmt_addr(mgmt_addr), .mgmt_way(mgmt_way),
        .mgmt_busy(mgmt_busy), .mgmt_ack(mgmt_ack),
        .tbl_lookup_en(tbl_lookup_en), .tbl_lookup_src_vlan(tbl_lookup_src_vlan),
        .tbl_lookup_src_mac(tbl_lookup_src_mac), .tbl_lookup_src_port(tbl_lookup_src_port),
        .tbl_lookup_dst_mac(tbl_lookup_dst_mac), .tbl_lookup_hit(tbl_lookup_hit),
        .tbl_lookup_dst_port(tbl_lookup_dst_port),
        .tbl_gc_en(tbl_gc_en), .tbl_gc_done(tbl_gc_done),
        .tbl_mgmt_rd_en(tbl_mgmt_rd_en), .tbl_mgmt_del_en(tbl_mgmt_del_en),
        .tbl_mgmt_addr(tbl_mgmt_addr), .tbl_mgmt_way(tbl_mgmt_way), .tbl_mgmt_ack(tbl_mgmt_ack)
    );

    // Table model: hit = dst_mac bit 1, dst_port = dst_mac[4:0], LAT cycles later
    logic       tm_hit  [LAT];
    logic [4:0] tm_port [LAT];
    always @(posedge clk) begin
        tm_hit[0]  <= tbl_lookup_dst_mac[1];
        tm_port[0] <= tbl_lookup_dst_mac[4:0];
        for (int i = 1; i < LAT; i++) begin
            tm_hit[i]  <= tm_hit[i-1];
            tm_port[i] <= tm_port[i-1];
        end
    end
    assign tbl_lookup_hit      = tm_hit[LAT-1];
    assign tbl_lookup_dst_port = tm_port[LAT-1];

    // Table GC / management responders with programmable delay
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gc_cd <= 0; mg_cd <= 0; tbl_gc_done <= 1'b0; tbl_mgmt_ack <= 1'b0;
        end else begin
            tbl_gc_done  <= 1'b0;
            tbl_mgmt_ack <= 1'b0;
            if (tbl_gc_en) gc_cd <= gc_delay;
            else if (gc_cd > 0) begin
                gc_cd <= gc_cd - 1;
                if (gc_cd == 1) tbl_gc_done <= 1'b1;
            end
            if (tbl_mgmt_rd_en || tbl_mgmt_del_en) mg_cd <= mg_delay;
            else if (mg_cd > 0) begin
                mg_cd <= mg_cd - 1;
                if (mg_cd == 1) tbl_mgmt_ack <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_en = '0; gc_force = 1'b0; mgmt_rd_en = 1'b0; mgmt_del_en = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        int r = 0;
        for (int i = 0; i < NP; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic push_grant(input logic [3:0] ack);
        int i = oh2idx(ack);
        exp_t e;
        e.cyc = cyc; e.vld = ack; e.hit = dst_tab[i][1]; e.dst = dst_tab[i][4:0];
        exp_q.push_back(e);
    endtask

    // Response monitor: ordering, routing, latency and payload
    initial forever begin
        @(posedge clk); #2;
        if (rst_n) begin
            if (rsp_valid != 4'd0) begin
                if (exp_q.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_valid", 64'(rsp_valid), 64'(mon_e.vld));
                    check("rsp_latency", 64'(cyc - mon_e.cyc), 64'd6);
                    check("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
                    check("rsp_dst_port", 64'(rsp_dst_port), 64'(mon_e.dst));
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 6) begin
                mon_e = exp_q.pop_front();
                check("rsp_missing", 64'(rsp_valid), 64'(mon_e.vld));
            end
        end
    end

    initial begin
        for (int i = 0; i < NP; i++) begin
            src_tab[i] = 48'h02deadbeef06 + 48'(3*i);
            dst_tab[i] = 48'h02deadbeef06 + 48'(2*i);
            req_vlan[i*12 +: 12]   = 12'(i);
            req_src_mac[i*48 +: 48] = src_tab[i];
            req_dst_mac[i*48 +: 48] = dst_tab[i];
        end
        vecs[0] = '{4'b0100, 4'b0100};
        vecs[1] = '{4'b1111, 4'b1000};
        vecs[2] = '{4'b1111, 4'b0001};
        vecs[3] = '{4'b0001, 4'b0001};
        vecs[4] = '{4'b0000, 4'b0000};
        vecs[5] = '{4'b1010, 4'b0010};
        vecs[6] = '{4'b1010, 4'b1000};
        vecs[7] = '{4'b0110, 4'b0010};
        vecs[8] = '{4'b1001, 4'b1000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_lookup_en", 64'(tbl_lookup_en), 64'd0);
        check("rst_gc_en", 64'(tbl_gc_en), 64'd0);
        check("rst_gc_busy", 64'(gc_busy), 64'd0);
        check("rst_mgmt_busy", 64'(mgmt_busy), 64'd0);
        check("rst_mgmt_ack", 64'(mgmt_ack), 64'd0);

        // Automatic GC: issue at 16, done at 19, next issue at 36
        do_reset();
        tick(15);
        check("gc_before_first", 64'(tbl_gc_en), 64'd0);
        tick();
        check("gc_first", 64'(tbl_gc_en), 64'd1);
        check("gc_busy_issue", 64'(gc_busy), 64'd1);
        for (int k = 17; k <= 37; k++) begin
            tick();
            check("gc_auto_en", 64'(tbl_gc_en), 64'(k == 36));
            check("gc_auto_busy", 64'(gc_busy), 64'(k <= 19 || k >= 36));
        end

        // Arbitration vectors
        do_reset();
        for (int v = 0; v < 9; v++) begin
            req_en = vecs[v].req;
            #1;
            check("req_ack", 64'(req_ack), 64'(vecs[v].ack));
            if (req_ack != 4'd0) push_grant(req_ack);
            tick();
            check("lookup_en", 64'(tbl_lookup_en), 64'(vecs[v].ack != 4'd0));
            if (vecs[v].ack != 4'd0)
                check("lookup_src_port", 64'(tbl_lookup_src_port), 64'(oh2idx(vecs[v].ack)));
            if (v == 0) begin
                check("lookup_vlan", 64'(tbl_lookup_src_vlan), 64'd2);
                check("lookup_src_mac", 64'(tbl_lookup_src_mac), 64'h02deadbeef0c);
                check("lookup_dst_mac", 64'(tbl_lookup_dst_mac), 64'h02deadbeef0a);
            end
        end

        // Fairness: all requesting, grants rotate 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            req_en = 4'b1111;
            #1;
            check("fair_ack", 64'(req_ack), 64'(4'b0001 << (k % 4)));
            if (req_ack != 4'd0) push_grant(req_ack);
            tick();
        end
        req_en = '0;
        tick(10);
        check("rsp_drained", 64'(exp_q.size()), 64'd0);

        // Deferred management: force GC and read together, GC first
        do_reset();
        gc_delay = 2; mg_delay = 1;
        gc_force = 1'b1; mgmt_rd_en = 1'b1; mgmt_addr = 11'h068; mgmt_way = 3'd0;
        tick();
        gc_force = 1'b0; mgmt_rd_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check("dm_gc_en", 64'(tbl_gc_en), 64'(k == 1));
            check("dm_rd_en", 64'(tbl_mgmt_rd_en), 64'(k == 6));
            check("dm_ack", 64'(mgmt_ack), 64'(k == 9));
            check("dm_busy", 64'(mgmt_busy), 64'(k <= 9));
            if (k == 6) begin
                check("dm_addr", 64'(tbl_mgmt_addr), 64'h068);
                check("dm_way", 64'(tbl_mgmt_way), 64'd0);
                check("dm_del_en", 64'(tbl_mgmt_del_en), 64'd0);
            end
            tick();
        end

        // Deferred GC: delete outstanding when the counter expires
        do_reset();
        gc_delay = 2; mg_delay = 20;
        mgmt_del_en = 1'b1; mgmt_addr = 11'h06e; mgmt_way = 3'd3;
        tick();
        mgmt_del_en = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            check("dg_gc_en", 64'(tbl_gc_en), 64'(k == 24));
            check("dg_ack", 64'(mgmt_ack), 64'(k == 23));
            check("dg_del_en", 64'(tbl_mgmt_del_en), 64'(k == 1));
            check("dg_gc_busy", 64'(gc_busy), 64'(k >= 24));
            if (k == 1) begin
                check("dg_addr", 64'(tbl_mgmt_addr), 64'h06e);
                check("dg_way", 64'(tbl_mgmt_way), 64'd3);
            end
            tick();
        end

        // Reset mid-sweep with a lookup and a pending read in flight
        do_reset();
        gc_delay = 50; mg_delay = 1;
        gc_force = 1'b1; mgmt_rd_en = 1'b1; mgmt_addr = 11'h011; req_en = 4'b0001;
        #1;
        check("rm_ack", 64'(req_ack), 64'd1);
        tick();
        gc_force = 1'b0; mgmt_rd_en = 1'b0; req_en = '0;
        tick(2);
        check("rm_gc_busy_wait", 64'(gc_busy), 64'd1);
        check("rm_mgmt_busy_pend", 64'(mgmt_busy), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rm_gc_busy_rst", 64'(gc_busy), 64'd0);
        check("rm_rsp_valid_rst", 64'(rsp_valid), 64'd0);
        check("rm_mgmt_busy_rst", 64'(mgmt_busy), 64'd0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("rm_gc_en", 64'(tbl_gc_en), 64'(k == 16));
            check("rm_no_ack", 64'(mgmt_ack), 64'd0);
            check("rm_no_rd", 64'(tbl_mgmt_rd_en), 64'd0);
        end

        tick(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
